// File: rtl/alu_sequencer.sv
// alu_sequencer: runs one operation at a time in front of an external 9-bit ALU.
//   ADD/SUB are sent to the ALU with a one-cycle strobe, and its registered result
//   is captured one cycle later. MUL/DIV run internally as WIDTH-step shift-add /
//   restoring-divide loops. SHIFT/ROT/illegal ops finish at the accept edge.
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake; req_op/req_a/req_b/req_dir latched on accept
//   alu_out/alu_op_add/_sub   ALU enable and function strobes (high only in ISSUE)
//   alu_register1/2           latched operands A/B driven to the ALU
//   alu_result                registered ALU result
//   rsp_valid/rsp_ready       response handshake; rsp_result/rsp_flag held until taken
module alu_sequencer #(
    parameter int WIDTH = 9,
    parameter int ITERS = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_dir,
    output logic             alu_out,
    output logic             alu_op_add,
    output logic             alu_op_sub,
    output logic [WIDTH-1:0] alu_register1,
    output logic [WIDTH-1:0] alu_register2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_flag
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ITER, RESP} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_hi, acc_lo;   // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] quick_res;
    logic             quick_flag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic             last_step;

    // Gated by reset so every output reads 0 while reset is held.
    assign req_ready     = (state == IDLE) && !reset;
    assign alu_register1 = a_q;
    assign alu_register2 = b_q;

    always_comb begin
        quick_res  = '0;
        quick_flag = 1'b1;
        case (req_op)
            3'd4: begin
                if (req_dir) begin
                    quick_res  = {1'b0, req_a[WIDTH-1:1]};
                    quick_flag = req_a[0];
                end else begin
                    quick_res  = {req_a[WIDTH-2:0], 1'b0};
                    quick_flag = req_a[WIDTH-1];
                end
            end
            3'd5: begin
                if (req_dir) begin
                    quick_res  = {req_a[0], req_a[WIDTH-1:1]};
                    quick_flag = req_a[0];
                end else begin
                    quick_res  = {req_a[WIDTH-2:0], req_a[WIDTH-1]};
                    quick_flag = req_a[WIDTH-1];
                end
            end
            default: begin
                quick_res  = '0;
                quick_flag = 1'b1;
            end
        endcase
    end

    // One shift-add step: add A when the multiplier LSB is set, then shift {sum, lo} right.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
    // One restoring-divide step: bring in the next dividend bit, subtract if it fits.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;
    assign last_step = (cnt == CW'(ITERS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            cnt        <= '0;
            alu_out    <= 1'b0;
            alu_op_add <= 1'b0;
            alu_op_sub <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        case (req_op)
                            3'd0, 3'd1: begin
                                alu_out    <= 1'b1;
                                alu_op_add <= (req_op == 3'd0);
                                alu_op_sub <= (req_op == 3'd1);
                                state      <= ISSUE;
                            end
                            3'd2: begin
                                acc_hi <= '0;
                                acc_lo <= req_b;
                                cnt    <= '0;
                                state  <= ITER;
                            end
                            3'd3: begin
                                acc_hi <= '0;
                                acc_lo <= req_a;
                                cnt    <= '0;
                                state  <= ITER;
                            end
                            default: begin
                                rsp_result <= quick_res;
                                rsp_flag   <= quick_flag;
                                rsp_valid  <= 1'b1;
                                state      <= RESP;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    alu_out    <= 1'b0;
                    alu_op_add <= 1'b0;
                    alu_op_sub <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    rsp_result <= alu_result;
                    rsp_flag   <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    if (op_q == 3'd2) begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end else begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end
                    if (last_step) begin
                        if (op_q == 3'd2) begin
                            rsp_result <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                            rsp_flag   <= |mul_sum[WIDTH:1];
                        end else begin
                            rsp_result <= (b_q == '0) ? '1 : {acc_lo[WIDTH-2:0], div_ge};
                            rsp_flag   <= (b_q == '0);
                        end
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural registered ALU.
module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [8:0] req_a, req_b;
    logic       req_dir;
    logic       alu_out, alu_op_add, alu_op_sub;
    logic [8:0] alu_register1, alu_register2;
    logic [8:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [8:0] rsp_result;
    logic       rsp_flag;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    alu_sequencer #(.WIDTH(9), .ITERS(9)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_dir(req_dir),
        .alu_out(alu_out), .alu_op_add(alu_op_add), .alu_op_sub(alu_op_sub),
        .alu_register1(alu_register1), .alu_register2(alu_register2),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag)
    );

    always #5 clock = ~clock;

    // External ALU: registers sum/difference of its operands when strobed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            alu_result <= '0;
        else if (alu_out && alu_op_add)
            alu_result <= alu_register1 + alu_register2;
        else if (alu_out && alu_op_sub)
            alu_result <= alu_register1 - alu_register2;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1. bp = cycles the response is held back.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [8:0] a,
                         input logic [8:0] b, input logic dir, input logic [8:0] exp_res,
                         input logic exp_flag, input int exp_lat, input int bp);
        int lat;
        int strobes;
        logic add_seen, sub_seen;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_dir   = dir;
        req_valid = 1'b1;
        rsp_ready = (bp == 0);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        check({tag, " operands"}, {14'd0, alu_register1, alu_register2}, {14'd0, a, b});
        lat = 1; strobes = 0; add_seen = 1'b0; sub_seen = 1'b0;
        while (!rsp_valid && lat < 20) begin
            if (alu_out) begin
                strobes++;
                add_seen = add_seen | alu_op_add;
                sub_seen = sub_seen | alu_op_sub;
            end
            @(posedge clock); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " strobes"}, strobes, (op <= 3'd1) ? 1 : 0);
        check({tag, " strobe_sel"}, {30'd0, add_seen, sub_seen}, {30'd0, op == 3'd0, op == 3'd1});
        check({tag, " result"}, {23'd0, rsp_result}, {23'd0, exp_res});
        check({tag, " flag"}, {31'd0, rsp_flag}, {31'd0, exp_flag});
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            @(posedge clock); #1;
            check({tag, " bp hold"}, {21'd0, rsp_valid, rsp_flag, req_ready, rsp_result},
                  {21'd0, 1'b1, exp_flag, 1'b0, exp_res});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        check({tag, " post rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " post req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 9'h1F0;
        req_b     = 9'h020;
        req_dir   = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        check("reset outputs",
              {req_ready, alu_out, alu_op_add, alu_op_sub, rsp_valid, rsp_flag},
              32'd0);
        check("reset regs", {alu_register1, alu_register2, rsp_result}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("ready after reset", {31'd0, req_ready}, 32'd1);

        do_op("ADD",  3'd0, 9'h1F0, 9'h020, 1'b0, 9'h010, 1'b0, 3, 0);
        do_op("SUB",  3'd1, 9'h005, 9'h007, 1'b0, 9'h1FE, 1'b0, 3, 0);
        do_op("MUL1", 3'd2, 9'd23,  9'd22,  1'b0, 9'h1FA, 1'b0, 10, 0);
        do_op("MUL2", 3'd2, 9'd30,  9'd20,  1'b0, 9'h058, 1'b1, 10, 0);
        do_op("DIV1", 3'd3, 9'd500, 9'd7,   1'b0, 9'h047, 1'b0, 10, 0);
        do_op("DIV0", 3'd3, 9'd5,   9'd0,   1'b0, 9'h1FF, 1'b1, 10, 0);
        do_op("ROTR", 3'd5, 9'h001, 9'h000, 1'b1, 9'h100, 1'b1, 1, 0);
        do_op("ROTL", 3'd5, 9'h101, 9'h000, 1'b0, 9'h003, 1'b1, 1, 0);
        do_op("SHL",  3'd4, 9'h180, 9'h000, 1'b0, 9'h100, 1'b1, 1, 0);
        do_op("SHR",  3'd4, 9'h002, 9'h000, 1'b1, 9'h001, 1'b0, 1, 0);
        do_op("ILL",  3'd7, 9'h123, 9'h045, 1'b0, 9'h000, 1'b1, 1, 0);
        do_op("BP",   3'd2, 9'd30,  9'd20,  1'b0, 9'h058, 1'b1, 10, 5);

        // Reset during MUL after four steps: operation must vanish.
        req_op = 3'd2; req_a = 9'd30; req_b = 9'd20; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midreset outputs", {29'd0, rsp_valid, req_ready, alu_out}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("midreset ready", {30'd0, req_ready, rsp_valid}, 32'd2);
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (i == 11) check("midreset no rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_op("ADD2", 3'd0, 9'h0FF, 9'h001, 1'b0, 9'h100, 1'b0, 3, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
